fixed_point_number_builder: RTL and testbench

- Accumulates a signed decimal number from a stream of BCD digits, one digit per `advance` strobe.
- Supports a decimal point; the result is scaled by 10^FRAC_DIGITS and emitted as two's complement.
- Sits in the parser after the digit/character classifier. Produces coordinates and feed values, e.g. "12.5" becomes 1250 with a `valid` strobe.
- Adds over the previous number builder: fraction digits, padding, saturation with an overflow flag, and a result/busy handshake.

---
 rtl/fixed_point_number_builder.sv | 153 +++++++++++++++
 tb/tb_fixed_point_number_builder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_number_builder.sv
// Builds a signed, 10^FRAC_DIGITS-scaled two's complement number from a BCD digit stream.
// Optional rounding on the first discarded fraction digit: define NUMBER_BUILDER_ROUND_EN.

`ifndef DIGIT_BITS
`define DIGIT_BITS 4
`endif

module fixed_point_number_builder #(
  parameter int NUM_BITS    = 16,
  parameter int FRAC_DIGITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   zero,
  input  logic [`DIGIT_BITS-1:0] digit,
  input  logic                   advance,
  input  logic                   point,
  input  logic                   finish,
  input  logic                   is_negative,
  output logic [NUM_BITS-1:0]    num,
  output logic                   valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int MAG_W = NUM_BITS - 1;
  localparam int EXT_W = NUM_BITS + 4;
  localparam int FC_W  = (FRAC_DIGITS > 0) ? $clog2(FRAC_DIGITS + 1) : 1;
  localparam logic [MAG_W-1:0] MAX_MAG = {MAG_W{1'b1}};
  localparam logic [EXT_W-1:0] MAX_EXT = {5'b0, MAX_MAG};

  typedef enum logic [1:0] {
    ST_INT,
    ST_FRAC,
    ST_PAD,
    ST_DONE
  } state_t;

  state_t            state;
  logic [MAG_W-1:0]  mag;
  logic [FC_W-1:0]   frac_cnt;

`ifdef NUMBER_BUILDER_ROUND_EN
  logic              round;
  logic              round_taken;
`endif

  logic [EXT_W-1:0]    mag_ext;
  logic [EXT_W-1:0]    acc_ext;
  logic [EXT_W-1:0]    pad_ext;
  logic [EXT_W-1:0]    fin_ext;
  logic                acc_ovf;
  logic                pad_ovf;
  logic                fin_ovf;
  logic [MAG_W-1:0]    acc_mag;
  logic [MAG_W-1:0]    pad_mag;
  logic [MAG_W-1:0]    fin_mag;
  logic [NUM_BITS-1:0] fin_abs;
  logic [NUM_BITS-1:0] fin_num;
  logic                frac_more;

  // All arithmetic is done wide enough that mag*10+9 never wraps, then clamped to MAX.
  always_comb begin
    mag_ext = {5'b0, mag};
    pad_ext = (mag_ext << 3) + (mag_ext << 1);
    acc_ext = pad_ext + EXT_W'(digit);
`ifdef NUMBER_BUILDER_ROUND_EN
    fin_ext = mag_ext + EXT_W'(round);
`else
    fin_ext = mag_ext;
`endif
    acc_ovf   = (acc_ext > MAX_EXT);
    pad_ovf   = (pad_ext > MAX_EXT);
    fin_ovf   = (fin_ext > MAX_EXT);
    acc_mag   = acc_ovf ? MAX_MAG : acc_ext[MAG_W-1:0];
    pad_mag   = pad_ovf ? MAX_MAG : pad_ext[MAG_W-1:0];
    fin_mag   = fin_ovf ? MAX_MAG : fin_ext[MAG_W-1:0];
    fin_abs   = {1'b0, fin_mag};
    fin_num   = is_negative ? -fin_abs : fin_abs;
    frac_more = (int'(frac_cnt) < FRAC_DIGITS);
  end

  always_ff @(posedge clk) begin
    if (reset || zero) begin
      state    <= ST_INT;
      mag      <= '0;
      frac_cnt <= '0;
      num      <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
`ifdef NUMBER_BUILDER_ROUND_EN
      round       <= 1'b0;
      round_taken <= 1'b0;
`endif
    end else if (clk_en) begin
      unique case (state)
        ST_INT: begin
          if (advance) begin
            mag      <= acc_mag;
            overflow <= overflow | acc_ovf;
          end
          // finish takes precedence over a simultaneous point
          if (finish)
            state <= ST_PAD;
          else if (point)
            state <= ST_FRAC;
        end

        ST_FRAC: begin
          if (advance) begin
            if (frac_more) begin
              mag      <= acc_mag;
              overflow <= overflow | acc_ovf;
              frac_cnt <= frac_cnt + 1'b1;
            end
`ifdef NUMBER_BUILDER_ROUND_EN
            else if (!round_taken) begin
              round       <= (digit >= `DIGIT_BITS'(5));
              round_taken <= 1'b1;
            end
`endif
          end
          if (finish)
            state <= ST_PAD;
        end

        ST_PAD: begin
          if (frac_more) begin
            mag      <= pad_mag;
            overflow <= overflow | pad_ovf;
            frac_cnt <= frac_cnt + 1'b1;
            busy     <= 1'b1;
          end else begin
            num      <= fin_num;
            valid    <= 1'b1;
            overflow <= overflow | fin_ovf;
            busy     <= 1'b0;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: state <= ST_INT;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_number_builder.sv
// Directed, table-driven bench for fixed_point_number_builder (NUM_BITS=16, FRAC_DIGITS=2).

module tb_fixed_point_number_builder;

`ifdef NUMBER_BUILDER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        zero;
  logic [3:0]  digit;
  logic        advance;
  logic        point;
  logic        finish;
  logic        is_negative;
  logic [15:0] num;
  logic        valid;
  logic        overflow;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  fixed_point_number_builder #(.NUM_BITS(16), .FRAC_DIGITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .zero(zero),
    .digit(digit),
    .advance(advance),
    .point(point),
    .finish(finish),
    .is_negative(is_negative),
    .num(num),
    .valid(valid),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n_int;
    logic [23:0] int_digits;
    bit          has_point;
    int          n_frac;
    logic [15:0] frac_digits;
    bit          neg;
    logic [15:0] exp_num;
    bit          exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic apply_stimulus(input bit adv, input logic [3:0] d, input bit pt, input bit fin);
    advance = adv;
    digit   = d;
    point   = pt;
    finish  = fin;
    tick();
    advance = 1'b0;
    digit   = 4'd0;
    point   = 1'b0;
    finish  = 1'b0;
  endtask

  task automatic clear_builder();
    zero = 1'b1;
    tick();
    zero = 1'b0;
  endtask

  // Called right after the finish edge; clk_en is dropped for edges freeze_lo..freeze_hi after it.
  task automatic wait_valid(input int freeze_lo, input int freeze_hi, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!valid && lat < 20) begin
      clk_en = (lat + 1 >= freeze_lo && lat + 1 <= freeze_hi) ? 1'b0 : 1'b1;
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    clk_en = 1'b1;
    if (!valid) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL timeout: valid not seen within %0d cycles", lat);
    end
  endtask

  task automatic run_vector(input vec_t v);
    int lat;
    int bcnt;
    logic [23:0] idg;
    logic [15:0] fdg;
    idg = v.int_digits;
    fdg = v.frac_digits;
    clear_builder();
    is_negative = v.neg;
    for (int i = 0; i < v.n_int; i++)
      apply_stimulus(1'b1, idg[4*(v.n_int-1-i) +: 4], 1'b0, 1'b0);
    if (v.has_point)
      apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < v.n_frac; i++)
      apply_stimulus(1'b1, fdg[4*(v.n_frac-1-i) +: 4], 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1);
    wait_valid(0, -1, lat, bcnt);
    check_output({v.name, ".num"}, 32'(num), 32'(v.exp_num));
    check_output({v.name, ".valid"}, 32'(valid), 32'd1);
    check_output({v.name, ".overflow"}, 32'(overflow), 32'(v.exp_ovf));
    check_output({v.name, ".latency"}, 32'(lat), 32'(v.exp_lat));
    check_output({v.name, ".busy_cycles"}, 32'(bcnt), 32'(v.exp_lat - 1));
  endtask

  initial begin
    int lat;
    int bcnt;

    vecs[0]  = '{"int12p5",   2, 24'h12,     1'b1, 1, 16'h5,   1'b0, 16'd1250,  1'b0,  2};
    vecs[1]  = '{"neg12p5",   2, 24'h12,     1'b1, 1, 16'h5,   1'b1, 16'hFB1E,  1'b0,  2};
    vecs[2]  = '{"pad_sat",   3, 24'h400,    1'b0, 0, 16'h0,   1'b0, 16'd32767, 1'b1,  3};
    vecs[3]  = '{"trunc",     1, 24'h3,      1'b1, 3, 16'h146, 1'b0, ROUND ? 16'd315 : 16'd314, 1'b0, 1};
    vecs[4]  = '{"int_sat",   6, 24'h999999, 1'b0, 0, 16'h0,   1'b0, 16'd32767, 1'b1,  3};
    vecs[5]  = '{"dot_only",  0, 24'h0,      1'b1, 0, 16'h0,   1'b0, 16'd0,     1'b0,  3};
    vecs[6]  = '{"neg_zero",  1, 24'h0,      1'b0, 0, 16'h0,   1'b1, 16'd0,     1'b0,  3};
    vecs[7]  = '{"neg_frac",  1, 24'h0,      1'b1, 2, 16'h05,  1'b1, 16'hFFFB,  1'b0,  1};
    vecs[8]  = '{"max_exact", 3, 24'h327,    1'b1, 2, 16'h67,  1'b0, 16'd32767, 1'b0,  1};
    vecs[9]  = '{"frac_sat",  3, 24'h327,    1'b1, 2, 16'h68,  1'b0, 16'd32767, 1'b1,  1};
    vecs[10] = '{"round_sat", 3, 24'h327,    1'b1, 3, 16'h675, 1'b0, 16'd32767, ROUND, 1};
    vecs[11] = '{"neg_max",   3, 24'h327,    1'b1, 2, 16'h67,  1'b1, 16'h8001,  1'b0,  1};

    reset = 1'b1;
    clk_en = 1'b1;
    zero = 1'b0;
    digit = 4'd0;
    advance = 1'b0;
    point = 1'b0;
    finish = 1'b0;
    is_negative = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_output("reset.num", 32'(num), 32'd0);
    check_output("reset.valid", 32'(valid), 32'd0);
    check_output("reset.overflow", 32'(overflow), 32'd0);
    check_output("reset.busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++)
      run_vector(vecs[i]);

    // After a negative result, zero clears the outputs on the very next edge
    run_vector(vecs[1]);
    zero = 1'b1;
    tick();
    zero = 1'b0;
    check_output("zero_after_neg.num", 32'(num), 32'd0);
    check_output("zero_after_neg.valid", 32'(valid), 32'd0);

    // Integer overflow is flagged before finish
    clear_builder();
    for (int i = 0; i < 6; i++)
      apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0);
    check_output("int_sat.early_overflow", 32'(overflow), 32'd1);
    check_output("int_sat.early_valid", 32'(valid), 32'd0);

    // advance+point, then advance+finish
    clear_builder();
    is_negative = 1'b0;
    apply_stimulus(1'b1, 4'd7, 1'b1, 1'b0);
    apply_stimulus(1'b1, 4'd2, 1'b0, 1'b1);
    wait_valid(0, -1, lat, bcnt);
    check_output("adv_pt_fin.num", 32'(num), 32'd720);
    check_output("adv_pt_fin.latency", 32'(lat), 32'd2);

    // point+finish together: finish wins, integer-only result
    clear_builder();
    apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1);
    wait_valid(0, -1, lat, bcnt);
    check_output("pt_fin.num", 32'(num), 32'd500);
    check_output("pt_fin.latency", 32'(lat), 32'd3);

    // DONE ignores further digits, points and finishes
    apply_stimulus(1'b1, 4'd7, 1'b1, 1'b1);
    apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0);
    check_output("done_hold.num", 32'(num), 32'd500);
    check_output("done_hold.valid", 32'(valid), 32'd1);

    // zero in DONE with advance high: clear wins and the digit is dropped
    zero = 1'b1;
    apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0);
    zero = 1'b0;
    check_output("zero_adv.num", 32'(num), 32'd0);
    check_output("zero_adv.valid", 32'(valid), 32'd0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1);
    wait_valid(0, -1, lat, bcnt);
    check_output("zero_adv.result", 32'(num), 32'd0);

    // clk_en low for 3 edges mid-PAD delays valid by exactly 3 cycles
    clear_builder();
    apply_stimulus(1'b1, 4'd4, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1);
    wait_valid(2, 4, lat, bcnt);
    check_output("clk_en_freeze.latency", 32'(lat), 32'd6);
    check_output("clk_en_freeze.num", 32'(num), 32'd400);
    check_output("clk_en_freeze.busy_cycles", 32'(bcnt), 32'd5);

    // reset mid-FRAC aborts the number, including the sticky overflow
    clear_builder();
    for (int i = 0; i < 6; i++)
      apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 4'd1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("reset_frac.num", 32'(num), 32'd0);
    check_output("reset_frac.valid", 32'(valid), 32'd0);
    check_output("reset_frac.overflow", 32'(overflow), 32'd0);
    check_output("reset_frac.busy", 32'(busy), 32'd0);
    apply_stimulus(1'b1, 4'd8, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1);
    wait_valid(0, -1, lat, bcnt);
    check_output("reset_frac.fresh_num", 32'(num), 32'd800);
    check_output("reset_frac.fresh_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
